// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the TDM link: FSM state encodings and the default
// frame geometry, also used by the transmit-side mux.
package tdm_demux_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } tdm_state_e;

    localparam int DEFAULT_NUM_CH = 4;
    localparam int DEFAULT_WIDTH  = 8;

endpackage

// File: rtl/tdm_demux_if.sv
// Link-side bus of the TDM demultiplexer: slot input plus per-channel
// outputs and status. The slave modport is the demux; master is the driver.
interface tdm_demux_if
    import tdm_demux_pkg::*;
#(
    parameter int NUM_CH = DEFAULT_NUM_CH,
    parameter int WIDTH  = DEFAULT_WIDTH
);
    logic [WIDTH-1:0]        in_data;
    logic                    in_valid;
    logic                    frame_sync;
    logic [NUM_CH*WIDTH-1:0] out_data;
    logic [NUM_CH-1:0]       out_strobe;
    logic                    frame_done;
    logic                    locked;
    logic                    sync_err;

    modport slave (
        input  in_data, in_valid, frame_sync,
        output out_data, out_strobe, frame_done, locked, sync_err
    );

    modport master (
        output in_data, in_valid, frame_sync,
        input  out_data, out_strobe, frame_done, locked, sync_err
    );
endinterface

// File: rtl/tdm_demux_slot_counter.sv
// Slot counter for the TDM demux. Clear has priority over load-to-1, which
// has priority over increment. Wraps at NUM_CH-1 so any channel count works.
module tdm_demux_slot_counter
    import tdm_demux_pkg::*;
#(
    parameter int NUM_CH = DEFAULT_NUM_CH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en_i,
    input  logic                      load1_i,
    input  logic                      clr_i,
    output logic [$clog2(NUM_CH)-1:0] slot_o,
    output logic                      at_last_o
);
    localparam int CW = $clog2(NUM_CH);

    logic [CW-1:0] slot_q;

    // Slot register with clear / load-to-1 / wrapping increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q <= '0;
        end else if (clr_i) begin
            slot_q <= '0;
        end else if (load1_i) begin
            slot_q <= CW'(1);
        end else if (en_i) begin
            slot_q <= at_last_o ? '0 : slot_q + CW'(1);
        end
    end

    assign at_last_o = (slot_q == CW'(NUM_CH - 1));
    assign slot_o    = slot_q;

endmodule

// File: rtl/tdm_demux.sv
// TDM demultiplexer: routes rotating slots of a shared bus into registered
// per-channel outputs, aligned by a frame-sync marker on slot 0.
// Optional feature macro TDM_DEMUX_FRAME_LATCH_EN: slots collect in a shadow
// bank and all channels update together when the last slot arrives.
//
// state  | meaning
// HUNT   | unaligned; discard samples until one carries frame_sync
// LOCKED | aligned; each sample goes to the channel of the current slot
module tdm_demux
    import tdm_demux_pkg::*;
#(
    parameter int NUM_CH = DEFAULT_NUM_CH,
    parameter int WIDTH  = DEFAULT_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    tdm_demux_if.slave  bus
);
    localparam int CW = $clog2(NUM_CH);

    tdm_state_e              state_q, state_d;
    logic [CW-1:0]           slot;
    logic                    at_last;
    logic                    cnt_en, cnt_load1, cnt_clr;
    logic                    wr_en;
    logic [CW-1:0]           wr_slot;
    logic                    done_d, err_d;
    logic [NUM_CH*WIDTH-1:0] out_data_q;
    logic [NUM_CH-1:0]       out_strobe_q;
    logic                    frame_done_q, sync_err_q;

    tdm_demux_slot_counter #(.NUM_CH(NUM_CH)) u_slot_cnt (
        .clk       (clk),
        .rst       (rst),
        .en_i      (cnt_en),
        .load1_i   (cnt_load1),
        .clr_i     (cnt_clr),
        .slot_o    (slot),
        .at_last_o (at_last)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= HUNT;
        else     state_q <= state_d;
    end

    // Next state, counter controls and slot write decisions for valid samples.
    always_comb begin
        state_d   = state_q;
        cnt_en    = 1'b0;
        cnt_load1 = 1'b0;
        cnt_clr   = 1'b0;
        wr_en     = 1'b0;
        wr_slot   = slot;
        done_d    = 1'b0;
        err_d     = 1'b0;
        if (bus.in_valid) begin
            case (state_q)
                HUNT: begin
                    if (bus.frame_sync) begin
                        wr_en     = 1'b1;
                        wr_slot   = '0;
                        cnt_load1 = 1'b1;
                        state_d   = LOCKED;
                    end
                end
                LOCKED: begin
                    if (bus.frame_sync) begin
                        // Sync always wins: realign to slot 0, flag if unexpected.
                        err_d     = (slot != '0);
                        wr_en     = 1'b1;
                        wr_slot   = '0;
                        cnt_load1 = 1'b1;
                    end else if (slot == '0) begin
                        err_d   = 1'b1;
                        cnt_clr = 1'b1;
                        state_d = HUNT;
                    end else begin
                        wr_en  = 1'b1;
                        cnt_en = 1'b1;
                        done_d = at_last;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Frame-done and sync-error pulses, one cycle after the sample edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            frame_done_q <= done_d;
            sync_err_q   <= err_d;
        end
    end

`ifdef TDM_DEMUX_FRAME_LATCH_EN
    logic [NUM_CH*WIDTH-1:0] shadow_q;

    // Shadow bank collects slots; an alignment fault throws the partial frame away.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
        end else begin
            if (err_d) shadow_q <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                if (wr_en && wr_slot == CW'(k)) shadow_q[k*WIDTH +: WIDTH] <= bus.in_data;
            end
        end
    end

    // Whole frame lands on the outputs together with the last slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q   <= '0;
            out_strobe_q <= '0;
        end else begin
            out_strobe_q <= '0;
            if (wr_en && done_d) begin
                out_data_q   <= {bus.in_data, shadow_q[(NUM_CH-1)*WIDTH-1:0]};
                out_strobe_q <= '1;
            end
        end
    end
`else
    // Each accepted sample updates its own channel and pulses its strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q   <= '0;
            out_strobe_q <= '0;
        end else begin
            out_strobe_q <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                if (wr_en && wr_slot == CW'(k)) begin
                    out_data_q[k*WIDTH +: WIDTH] <= bus.in_data;
                    out_strobe_q[k]              <= 1'b1;
                end
            end
        end
    end
`endif

    assign bus.out_data   = out_data_q;
    assign bus.out_strobe = out_strobe_q;
    assign bus.frame_done = frame_done_q;
    assign bus.sync_err   = sync_err_q;
    assign bus.locked     = (state_q == LOCKED);

endmodule

// File: doc/tdm_demux.md
# tdm_demux

Time-division demultiplexer: receives one shared data bus carrying NUM_CH channels in rotating slots and routes each slot into its own registered per-channel output. It is the receive end of the slot-multiplexed link the lab mux datapath drives. It sits between the link input and the per-channel consumers (display, LEDs, checkers). A frame-sync marker on slot 0 aligns the slot counter; loss of alignment is detected and reported.

## Interface
- NUM_CH, 4, number of channels per frame; legal range 2..16.
- WIDTH, 8, data bits per slot.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  WIDTH  slot payload.
- in_valid  in  1  in_data and frame_sync are meaningful this cycle; low = stall.
- frame_sync  in  1  qualifies the current valid sample as slot 0.
- out_data  out  NUM_CH*WIDTH  channel k at bits [k*WIDTH +: WIDTH].
- out_strobe  out  NUM_CH  one-cycle pulse per channel whose out_data changed.
- frame_done  out  1  one-cycle pulse when slot NUM_CH-1 is accepted.
- locked  out  1  high in LOCKED state.
- sync_err  out  1  one-cycle pulse on an alignment fault.

## Operation
- Reset values: out_data 0, out_strobe 0, frame_done 0, locked 0, sync_err 0, slot counter 0, state HUNT.
- Only cycles with in_valid=1 are samples. in_valid=0 freezes the counter and all state; all pulses are 0.
- HUNT: samples without frame_sync are discarded. A sample with frame_sync is accepted as slot 0; the counter moves to 1 and the state moves to LOCKED.
- LOCKED: each sample is written to channel slot. The counter increments and wraps from NUM_CH-1 to 0. frame_done pulses on slot NUM_CH-1.
- frame_sync on a sample whose expected slot is not 0: sync_err pulses. The sample is accepted as slot 0, the counter moves to 1, and the state stays LOCKED (resync).
- No frame_sync on a sample whose expected slot is 0: sync_err pulses, the sample is discarded, and the state goes to HUNT with locked=0.
- frame_sync on expected slot 0: normal, no error.
- Slot counter width is $clog2(NUM_CH). The wrap compare is against NUM_CH-1 explicitly, so non-power-of-two NUM_CH is legal.
- Reset mid-frame clears everything immediately, including partially filled frames.

## Timing
- Latency is 1 cycle. A sample accepted at edge n appears on out_data with its out_strobe bit high after edge n.
- frame_done, sync_err and locked are registered and share the same 1-cycle latency.
- Back-to-back valid samples give full throughput, one slot per cycle.
- out_data holds between updates. Strobes never stay high for more than one cycle per accepted sample.

## Configuration
- TDM_DEMUX_FRAME_LATCH_EN, defined:
  - Slots go into a shadow register bank.
  - When slot NUM_CH-1 is accepted, all channels copy to out_data at once; all out_strobe bits pulse in the same cycle as frame_done.
  - A resync or drop to HUNT discards the shadow contents, so out_data is unchanged.
- TDM_DEMUX_FRAME_LATCH_EN, undefined:
  - Each channel updates individually as described in Operation; only that channel's strobe pulses.
  - Data from partial frames is visible.

## Structure
- Shared package/header tdm_defs holds:
  - the state encodings HUNT=1'b0 and LOCKED=1'b1;
  - the default NUM_CH and WIDTH values, shared with the transmit-side mux.
- One sub-module, tdm_slot_counter, contains:
  - the enable, load-to-1 and clear-to-0 controls;
  - a wrap at NUM_CH-1;
  - outputs slot and at_last.
- The FSM, the channel registers and the optional shadow bank stay in tdm_demux.

## Test plan
- Reset, then stream 0xA0,0xA1,0xA2,0xA3 with frame_sync on 0xA0 → out_data = {A3,A2,A1,A0}; strobes 0001,0010,0100,1000 on successive cycles; frame_done with the 0xA3 update; locked=1.
- Samples 0x11,0x22 before any frame_sync → discarded: out_data stays 0, locked=0, no strobes.
- Locked, with in_valid low for 3 cycles between slot 1 and slot 2 → no output change during the gap; slot 2 resumes into channel 2 and the frame completes normally.
- Locked, with frame_sync asserted on slot 2 carrying 0x55 → sync_err pulse; channel 0 = 0x55; the next sample goes to channel 1.
- Locked, next frame starts without frame_sync → sync_err pulse, locked=0, sample dropped; relock on the next frame_sync.
- With TDM_DEMUX_FRAME_LATCH_EN, stream a full frame 0x10..0x13 → out_data unchanged until the last slot, then all four channels update and all strobes = 1111 in the frame_done cycle. Assert rst mid-frame → all outputs return to 0 asynchronously.
